// File: rtl/sample_fade_stage.sv
// Output conditioning stage ahead of the codec: linear fade-in/out gain plus
// static shift attenuation, all advancing once per codec frame.
module sample_fade_stage #(
    parameter int SAMPLE_WIDTH = 18,
    parameter int FADE_LOG2    = 6,
    parameter int VOL_WIDTH    = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    new_frame,
    input  logic                    play_enable,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic [VOL_WIDTH-1:0]    volume,
    output logic [SAMPLE_WIDTH-1:0] sample_out,
    output logic                    muted,
    output logic                    fade_busy
);

    localparam int GAIN_W = FADE_LOG2 + 1;
    localparam int PROD_W = SAMPLE_WIDTH + FADE_LOG2 + 1;
    localparam logic [GAIN_W-1:0] GMAX = GAIN_W'(1) << FADE_LOG2;

    typedef enum logic [1:0] {
        MUTED    = 2'd0,
        FADE_IN  = 2'd1,
        PLAYING  = 2'd2,
        FADE_OUT = 2'd3
    } state_t;

    state_t                    state_q, state_nxt;
    logic [GAIN_W-1:0]         gain_q, gain_nxt;
    logic signed [PROD_W-1:0]  prod_p0;
    logic signed [SAMPLE_WIDTH-1:0] scaled_p0;
    logic signed [SAMPLE_WIDTH-1:0] sample_p1;

    // Both shifts floor toward -inf; the result always fits the sample width
    // because gain never exceeds 2**FADE_LOG2, so truncation needs no saturation.
    function automatic logic signed [SAMPLE_WIDTH-1:0] attenuate(
        input logic signed [PROD_W-1:0] prod,
        input logic [VOL_WIDTH-1:0]     vol
    );
        return SAMPLE_WIDTH'((prod >>> FADE_LOG2) >>> vol);
    endfunction

    // Stage p0: gain multiply and attenuation, using the pre-step gain
    always_comb begin
        prod_p0   = $signed(sample_in) * $signed({1'b0, gain_q});
        scaled_p0 = attenuate(prod_p0, volume);
    end

    always_comb begin
        gain_nxt  = gain_q;
        state_nxt = state_q;
        if (new_frame) begin
            if (play_enable)
                gain_nxt = (gain_q == GMAX) ? GMAX : gain_q + GAIN_W'(1);
            else
                gain_nxt = (gain_q == '0) ? '0 : gain_q - GAIN_W'(1);

            if (play_enable)
                state_nxt = (gain_nxt == GMAX) ? PLAYING : FADE_IN;
            else
                state_nxt = (gain_nxt == '0) ? MUTED : FADE_OUT;
        end
    end

    // Stage p1: registered result held for the codec until the next frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_p1 <= '0;
            gain_q    <= '0;
            state_q   <= MUTED;
        end else begin
            gain_q  <= gain_nxt;
            state_q <= state_nxt;
            if (new_frame)
                sample_p1 <= scaled_p0;
        end
    end

    assign sample_out = sample_p1;
    assign muted      = (state_q == MUTED);
    assign fade_busy  = (state_q == FADE_IN) || (state_q == FADE_OUT);

endmodule
